// File: rtl/cp0_unit_pkg.sv
// Shared CPU definitions for the CP0 coprocessor:
// register indices, exception cause codes and the handler base.
package cp0_unit_pkg;

   localparam logic [4:0]  CP0_STATUS    = 5'd12;
   localparam logic [4:0]  CP0_CAUSE     = 5'd13;
   localparam logic [4:0]  CP0_EPC       = 5'd14;

   localparam logic [4:0]  CAUSE_SYSCALL = 5'd8;
   localparam logic [4:0]  CAUSE_BREAK   = 5'd9;
   localparam logic [4:0]  CAUSE_TEQ     = 5'd13;

   localparam logic [31:0] EXC_BASE      = 32'h0040_0000;
   localparam int          STATUS_SHIFT  = 5;

   // Registers owned by the trap/eret path when one is in flight
   function automatic logic is_exc_reg(input logic [4:0] a);
      return (a >= CP0_STATUS) && (a <= CP0_EPC);
   endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// CPU <-> CP0 bundle: move-to/from requests, trap/eret
// controls, and the combinational read-back paths.
interface cp0_unit_if;

   logic        mfc0;
   logic        mtc0;
   logic [31:0] pc;
   logic [4:0]  addr;
   logic [31:0] data;
   logic        exception;
   logic        eret;
   logic [4:0]  cause;
   logic [31:0] rdata;
   logic [31:0] status;
   logic [31:0] exc_addr;

   modport master (
      output mfc0, mtc0, pc, addr, data,
      output exception, eret, cause,
      input  rdata, status, exc_addr
   );

   modport slave (
      input  mfc0, mtc0, pc, addr, data,
      input  exception, eret, cause,
      output rdata, status, exc_addr
   );

endinterface

// File: rtl/cp0_unit.sv
// MIPS-style CP0: 32x32 register file with Status/Cause/EPC
// updated by trap entry and eret; reads are combinational.
module cp0_unit
   import cp0_unit_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   cp0_unit_if.slave bus
);

   logic [31:0] r_regs [32];

   logic        w_trap;
   logic        w_eret;
   logic        w_mtc0_en;
   logic [31:0] w_status;
   logic [31:0] w_epc;

   assign w_status = r_regs[CP0_STATUS];
   assign w_epc    = r_regs[CP0_EPC];

   always_comb begin
      w_trap    = bus.exception & ~bus.eret;
      w_eret    = bus.exception &  bus.eret;
      // trap/eret own Status/Cause/EPC on a colliding edge
      w_mtc0_en = bus.mtc0
                & ~(bus.exception & is_exc_reg(bus.addr));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         if (w_mtc0_en) begin
            r_regs[bus.addr] <= bus.data;
         end
         if (w_trap) begin
            r_regs[CP0_EPC]    <= bus.pc;
            r_regs[CP0_STATUS] <= w_status << STATUS_SHIFT;
            r_regs[CP0_CAUSE]  <= {25'b0, bus.cause, 2'b00};
         end else if (w_eret) begin
            r_regs[CP0_STATUS] <= w_status >> STATUS_SHIFT;
         end
      end
   end

   assign bus.rdata    = bus.mfc0 ? r_regs[bus.addr] : 32'h0;
   assign bus.status   = w_status;
   assign bus.exc_addr = bus.eret ? w_epc : EXC_BASE;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset, mtc0/mfc0, trap entry,
// eret, collisions, shift boundaries and async reset.
module tb_cp0_unit;
   import cp0_unit_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   passed = 0;

   cp0_unit_if bus ();

   cp0_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %08h expected %08h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.mtc0      = 1'b0;
      bus.exception = 1'b0;
      bus.eret      = 1'b0;
   endtask

   task automatic rd(input string tag,
                     input logic [4:0] a,
                     input logic [31:0] exp);
      bus.mfc0 = 1'b1;
      bus.addr = a;
      #1;
      chk(tag, bus.rdata, exp);
   endtask

   task automatic wr(input logic [4:0] a,
                     input logic [31:0] d);
      bus.mtc0 = 1'b1;
      bus.addr = a;
      bus.data = d;
      tick();
      idle();
   endtask

   task automatic trap(input logic [31:0] p,
                       input logic [4:0] c);
      bus.exception = 1'b1;
      bus.eret      = 1'b0;
      bus.pc        = p;
      bus.cause     = c;
      tick();
      idle();
   endtask

   task automatic do_eret();
      bus.exception = 1'b1;
      bus.eret      = 1'b1;
      tick();
      idle();
   endtask

   initial begin
      bus.mfc0      = 1'b0;
      bus.mtc0      = 1'b0;
      bus.pc        = 32'h0;
      bus.addr      = 5'd0;
      bus.data      = 32'h0;
      bus.exception = 1'b0;
      bus.eret      = 1'b0;
      bus.cause     = 5'd0;

      // reset state
      #2;
      rd("rst_rdata", CP0_STATUS, 32'h0);
      chk("rst_status", bus.status, 32'h0);
      chk("rst_exc_addr", bus.exc_addr, 32'h0040_0000);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // mfc0 disabled reads zero
      bus.mfc0 = 1'b0;
      #1;
      chk("mfc0_off", bus.rdata, 32'h0);

      // mtc0 / mfc0
      wr(CP0_STATUS, 32'h0000_001F);
      chk("mtc0_status", bus.status, 32'h1F);
      rd("mfc0_status", CP0_STATUS, 32'h1F);

      // no bypass: new value only after the edge
      bus.mtc0 = 1'b1;
      bus.addr = 5'd5;
      bus.data = 32'hA5A5_0001;
      bus.mfc0 = 1'b1;
      #1;
      chk("no_bypass", bus.rdata, 32'h0);
      tick();
      idle();
      rd("wr_visible", 5'd5, 32'hA5A5_0001);

      // trap entry (syscall)
      bus.exception = 1'b1;
      bus.pc        = 32'h0040_0010;
      bus.cause     = CAUSE_SYSCALL;
      #1;
      chk("trap_exc_addr", bus.exc_addr, 32'h0040_0000);
      tick();
      idle();
      rd("trap_epc", CP0_EPC, 32'h0040_0010);
      rd("trap_cause", CP0_CAUSE, 32'h20);
      chk("trap_status", bus.status, 32'h3E0);

      // eret
      bus.exception = 1'b1;
      bus.eret      = 1'b1;
      #1;
      chk("eret_exc_addr", bus.exc_addr, 32'h0040_0010);
      tick();
      idle();
      chk("eret_status", bus.status, 32'h1F);
      rd("eret_epc", CP0_EPC, 32'h0040_0010);
      rd("eret_cause", CP0_CAUSE, 32'h20);

      // eret without exception is a no-op
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      chk("eret_noop", bus.status, 32'h1F);

      // collision: trap beats mtc0 to EPC
      bus.mtc0      = 1'b1;
      bus.addr      = CP0_EPC;
      bus.data      = 32'hDEAD_BEEF;
      bus.exception = 1'b1;
      bus.pc        = 32'h0040_0020;
      bus.cause     = CAUSE_BREAK;
      tick();
      idle();
      rd("coll_epc", CP0_EPC, 32'h0040_0020);
      rd("coll_cause", CP0_CAUSE, 32'h24);
      chk("coll_status", bus.status, 32'h3E0);

      // mtc0 to other index completes beside a trap
      bus.mtc0      = 1'b1;
      bus.addr      = 5'd3;
      bus.data      = 32'h0000_1234;
      bus.exception = 1'b1;
      bus.pc        = 32'h0040_0030;
      bus.cause     = CAUSE_TEQ;
      tick();
      idle();
      rd("side_wr", 5'd3, 32'h0000_1234);
      rd("side_epc", CP0_EPC, 32'h0040_0030);
      rd("side_cause", CP0_CAUSE, 32'h34);
      chk("side_status", bus.status, 32'h7C00);

      // mtc0 to Cause blocked during eret
      bus.mtc0      = 1'b1;
      bus.addr      = CP0_CAUSE;
      bus.data      = 32'hFFFF_FFFF;
      bus.exception = 1'b1;
      bus.eret      = 1'b1;
      tick();
      idle();
      rd("eret_coll_cause", CP0_CAUSE, 32'h34);
      chk("eret_coll_status", bus.status, 32'h3E0);

      // shift boundaries
      wr(CP0_STATUS, 32'hF800_0001);
      trap(32'h0040_0040, CAUSE_SYSCALL);
      chk("shl_drop", bus.status, 32'h20);
      do_eret();
      chk("shr_back", bus.status, 32'h1);
      wr(CP0_STATUS, 32'h8000_0000);
      do_eret();
      chk("shr_logical", bus.status, 32'h0400_0000);

      // async reset between edges
      wr(5'd7, 32'h7777_7777);
      #2;
      rst = 1'b1;
      #1;
      rd("arst_r7", 5'd7, 32'h0);
      rd("arst_r3", 5'd3, 32'h0);
      rd("arst_epc", CP0_EPC, 32'h0);
      chk("arst_status", bus.status, 32'h0);

      // reset beats mtc0 and trap
      bus.mtc0      = 1'b1;
      bus.addr      = 5'd7;
      bus.data      = 32'h1111_1111;
      bus.exception = 1'b1;
      bus.pc        = 32'h0040_0050;
      tick();
      idle();
      rd("rst_prio_r7", 5'd7, 32'h0);
      rd("rst_prio_epc", CP0_EPC, 32'h0);
      rst = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
